serial_word_transmitter: RTL

SERIAL_WORD_TRANSMITTER -- requirements
Module: serial_word_transmitter

---
 rtl/serial_tx_pkg.sv | 8 +
 rtl/serial_bit_counter.sv | 20 ++
 rtl/serial_word_transmitter.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared FSM encoding, default word length and counter-width helper
package serial_tx_pkg;
   localparam int DEFAULT_DATA_WIDTH = 16;
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} tx_state_e;
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction
endpackage

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: counts 0..N-1 and flags the terminal value
module serial_bit_counter
   import serial_tx_pkg::*;
#(
   parameter int N  = DEFAULT_DATA_WIDTH,
   parameter int CW = cnt_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          tc_o
);
   logic [CW-1:0] count_q;
   always_ff @(posedge clk)
      count_q <= (rst || clr_i) ? '0 : en_i ? count_q + CW'(1) : count_q;
   assign count_o = count_q;
   assign tc_o    = count_q == CW'(N - 1);
endmodule

// File: rtl/serial_word_transmitter.sv
// serial_word_transmitter: LSB-first word serializer with ready/valid intake and frame counter.
// Defining SERIAL_TX_PARITY_EN appends an even-parity bit to every frame.
module serial_word_transmitter
   import serial_tx_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Data_Valid_In,
   output logic                  Data_Ready_Out,
   output logic                  Serial_Data_Out,
   output logic                  Serial_Valid_Out,
   output logic                  Busy_Out,
   output logic [15:0]           Words_Sent_Out
);
   localparam int CW = cnt_width(DATA_WIDTH);
`ifdef SERIAL_TX_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
   logic parity_q;
`else
   localparam bit PARITY_EN = 1'b0;
`endif
   tx_state_e             state_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  data_q, valid_q, busy_q, ready_q;
   logic [15:0]           words_q;
   logic [CW-1:0]         count;
   logic                  tc, accept, last_bit, next_last, frame_done;

   assign accept    = Data_Valid_In & ready_q;
   assign last_bit  = (state_q == SHIFT) && tc;
   assign next_last = count == CW'(DATA_WIDTH - 2);
`ifdef SERIAL_TX_PARITY_EN
   assign frame_done = state_q == PARITY;
`else
   assign frame_done = last_bit;
`endif

   serial_bit_counter #(.N(DATA_WIDTH)) u_bit_counter (
      .clk    (Clk_In),
      .rst    (Reset_In),
      .clr_i  (accept),
      .en_i   ((state_q == SHIFT) && !tc),
      .count_o(count),
      .tc_o   (tc)
   );

   // Accepting during the last bit reloads the shifter so frames run back to back.
   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         state_q <= IDLE;
         shift_q <= '0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         words_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         if (frame_done) words_q <= words_q + 16'd1;
         if (accept) begin
            state_q <= SHIFT;
            shift_q <= Data_In >> 1;
            data_q  <= Data_In[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= ^Data_In;
`endif
         end else if ((state_q == SHIFT) && !tc) begin
            shift_q <= shift_q >> 1;
            data_q  <= shift_q[0];
            ready_q <= !PARITY_EN && next_last;
         end
`ifdef SERIAL_TX_PARITY_EN
         else if (last_bit) begin
            state_q <= PARITY;
            data_q  <= parity_q;
            ready_q <= 1'b0;
         end
`endif
         else begin
            state_q <= IDLE;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
         end
      end
   end

   assign Data_Ready_Out   = ready_q;
   assign Serial_Data_Out  = data_q;
   assign Serial_Valid_Out = valid_q;
   assign Busy_Out         = busy_q;
   assign Words_Sent_Out   = words_q;
endmodule
